sd_block_sched: RTL

- Schedules single-sector SD block transfers between the HPS virtual-disk interface and up to NREQ independent requesters (ZPU drive emulator, cartridge loader, future tape/state-save agents).
- Drives the hps_io sd_lba/sd_rd/sd_wr/sd_ack handshake.
- Arbitrates round-robin between requesters and returns per-requester completion or timeout status.
- Sits between requesters and hps_io. The sector buffer dpram is outside this block; the block exports the current grant so the buffer port-B mux can follow it.

---
 rtl/sd_block_sched_pkg.sv | 42 ++++
 rtl/sd_block_sched_if.sv | 14 +
 rtl/sd_block_sched_rr_arbiter.sv | 25 ++
 rtl/sd_block_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sd_block_sched_pkg.sv
// Shared types and helpers for the SD block scheduler.
//   state_e  : scheduler FSM states
//   LBA_W    : sector address width
//   rr_pick  : round-robin pick over up to four requesters
package sd_sched_pkg;

  localparam int LBA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Scans valid starting at ptr+1 (mod n). The loop runs from the farthest
  // offset down to the nearest so the nearest set bit is the last assignment.
  function automatic pick_t rr_pick(input logic [3:0] valid,
                                    input logic [1:0] ptr,
                                    input int         n);
    pick_t r;
    int    cand;
    r = '0;
    for (int k = 4; k >= 1; k--) begin
      if (k <= n) begin
        cand = int'(ptr) + k;
        if (cand >= n) cand = cand - n;
        if (valid[cand[1:0]]) begin
          r.found = 1'b1;
          r.idx   = cand[1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sd_block_sched_if.sv
// hps_io virtual-disk handshake.
//   master : scheduler side (drives sd_lba/sd_rd/sd_wr, receives sd_ack)
//   slave  : hps_io side
interface sd_block_sched_if #(parameter int NDRV = 3);
  import sd_sched_pkg::*;

  logic [LBA_W-1:0] sd_lba;
  logic [NDRV-1:0]  sd_rd;
  logic [NDRV-1:0]  sd_wr;
  logic             sd_ack;

  modport master (output sd_lba, sd_rd, sd_wr, input  sd_ack);
  modport slave  (input  sd_lba, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/sd_block_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid_i : request vector
//   ptr_i   : index of the last requester served
//   grant_o : winning index
//   found_o : at least one request present
module rr_arbiter
  import sd_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [1:0]   ptr_i,
  output logic [1:0]   grant_o,
  output logic         found_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(4'(valid_i), ptr_i, N);
    grant_o = pick.idx;
    found_o = pick.found;
  end

endmodule

// File: rtl/sd_block_sched.sv
// Single-sector SD transfer scheduler between NREQ requesters and hps_io.
//   clk_sys, areset (sync, active high)
//   req_valid_i/req_wr_i/req_drv_i/req_lba_i : packed per-requester request
//   req_done_o/req_err_o : one-cycle completion pulse, err = timeout/bad drive
//   grant_o : requester owning the sector buffer, busy_o : transfer active
//   sd : hps_io handshake (master side)
module sd_block_sched
  import sd_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int NDRV  = 3,
  parameter int TMO_W = 24
) (
  input  logic                  clk_sys,
  input  logic                  areset,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ-1:0]       req_wr_i,
  input  logic [2*NREQ-1:0]     req_drv_i,
  input  logic [LBA_W*NREQ-1:0] req_lba_i,
  output logic [NREQ-1:0]       req_done_o,
  output logic [NREQ-1:0]       req_err_o,
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  sd_block_sched_if.master      sd
);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, grant_q, drv_q;
  logic [LBA_W-1:0] lba_q;
  logic             wr_q, err_q, old_ack_q;
  logic [TMO_W-1:0] tmo_q;
  logic [NDRV-1:0]  rd_out_q, wr_out_q;

  logic [1:0]       pick_idx;
  logic             pick_found;
  logic [LBA_W-1:0] sel_lba;
  logic [1:0]       sel_drv;
  logic             sel_wr;
  logic             drv_ok, tmo_end, ack_fall;
  logic [NDRV-1:0]  drv_onehot;

  rr_arbiter #(.N(NREQ)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    sel_lba = '0;
    sel_drv = '0;
    sel_wr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_lba = req_lba_i[i*LBA_W +: LBA_W];
        sel_drv = req_drv_i[i*2 +: 2];
        sel_wr  = req_wr_i[i];
      end
    end
  end

  assign drv_ok     = int'(drv_q) < NDRV;
  assign drv_onehot = NDRV'(1) << drv_q;
  assign tmo_end    = &tmo_q;
  assign ack_fall   = old_ack_q & ~sd.sd_ack;

  // State register and latched transfer context
  always_ff @(posedge clk_sys) begin
    if (areset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      drv_q     <= '0;
      lba_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      old_ack_q <= 1'b0;
      tmo_q     <= '0;
      rd_out_q  <= '0;
      wr_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      old_ack_q <= sd.sd_ack;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            lba_q   <= sel_lba;
            drv_q   <= sel_drv;
            wr_q    <= sel_wr;
            err_q   <= 1'b0;
            tmo_q   <= '0;
          end
        end
        ISSUE: begin
          tmo_q <= tmo_q + 1'b1;
          if (state_d == ISSUE) begin
            rd_out_q <= wr_q ? '0 : drv_onehot;
            wr_out_q <= wr_q ? drv_onehot : '0;
          end else begin
            rd_out_q <= '0;
            wr_out_q <= '0;
          end
          if (state_d == DONE) err_q <= 1'b1;
        end
        XFER: begin
          tmo_q <= tmo_q + 1'b1;
          if (tmo_end && !ack_fall) err_q <= 1'b1;
        end
        DONE: ptr_q <= grant_q;
        default: ;
      endcase
    end
  end

  // Next-state logic; an ack in the same cycle as timeout counts as an ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pick_found) state_d = ISSUE;
      ISSUE: begin
        if (!drv_ok)         state_d = DONE;
        else if (sd.sd_ack)  state_d = XFER;
        else if (tmo_end)    state_d = DONE;
      end
      XFER:  if (ack_fall || tmo_end) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_done_o = '0;
    req_err_o  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (state_q == DONE && grant_q == 2'(i)) begin
        req_done_o[i] = 1'b1;
        req_err_o[i]  = err_q;
      end
    end
    busy_o    = (state_q != IDLE);
    grant_o   = grant_q;
    sd.sd_lba = lba_q;
    sd.sd_rd  = rd_out_q;
    sd.sd_wr  = wr_out_q;
  end

endmodule
